vu_vxu_alu_seq: RTL and testbench

VU_VXU_ALU_SEQ -- requirements
Module: vu_vxu_alu_seq

---
 rtl/vu_vxu_alu_seq.sv | 166 ++++++++++++++++
 tb/tb_vu_vxu_alu_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_vxu_alu_seq.sv
// vu_vxu_alu_seq: sequences one vector ALU op element by element through
// operand read (stage 1), ALU issue (stage 2) and writeback (stage 3).
// Optional feature macro: VU_ALU_SEQ_SCALAR_EN adds a scalar operand that
// replaces rd_data1 for every element when enabled at issue time.
module vu_vxu_alu_seq #(
  parameter int ALU_LAT   = 1,   // external ALU latency; only 1 is legal
  parameter int SZ_VIU_FN = 8,
  parameter int SZ_VLEN   = 8,
  parameter int SZ_DATA   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 issue_val,
  output logic                 issue_rdy,
  input  logic [SZ_VIU_FN-1:0] issue_fn,
  input  logic [SZ_VLEN-1:0]   issue_vlen,
`ifdef VU_ALU_SEQ_SCALAR_EN
  input  logic                 issue_scalar_en,
  input  logic [SZ_DATA-1:0]   issue_scalar,
`endif
  input  logic                 stall,
  output logic                 rd_val,
  output logic [SZ_VLEN-1:0]   rd_utidx,
  input  logic [SZ_DATA-1:0]   rd_data0,
  input  logic [SZ_DATA-1:0]   rd_data1,
  output logic                 alu_val,
  output logic                 alu_wen,
  output logic [SZ_VIU_FN-1:0] alu_fn,
  output logic [SZ_VLEN-1:0]   alu_utidx,
  output logic [SZ_DATA-1:0]   alu_in0,
  output logic [SZ_DATA-1:0]   alu_in1,
  input  logic                 alu_wen_masked,
  input  logic [SZ_DATA-1:0]   alu_out,
  output logic                 wb_val,
  output logic [SZ_VLEN-1:0]   wb_utidx,
  output logic [SZ_DATA-1:0]   wb_data,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [SZ_VLEN:0]     r_cnt, w_cnt_nxt;      // one extra bit so max vlen never wraps
  logic [SZ_VIU_FN-1:0] r_fn;
  logic [SZ_VLEN-1:0]   r_vlen;
  logic                 r_out_en;              // holds issue_rdy low until first edge after reset
  logic                 r_s2_val;
  logic [SZ_VLEN-1:0]   r_s2_idx;
  logic [ALU_LAT-1:0]   r_s3_val;
  logic [SZ_VLEN-1:0]   r_s3_idx [ALU_LAT];
`ifdef VU_ALU_SEQ_SCALAR_EN
  logic                 r_scalar_en;
  logic [SZ_DATA-1:0]   r_scalar;
`endif

  logic                 w_accept;
  logic                 w_in_flight;
  logic                 w_s3_val;
  logic [SZ_VLEN:0]     w_last;

  assign issue_rdy   = (r_state == S_IDLE) && r_out_en;
  assign w_accept    = issue_rdy && issue_val;
  assign w_last      = {1'b0, r_vlen} - (SZ_VLEN + 1)'(1);
  assign w_in_flight = r_s2_val || (|r_s3_val);
  assign rd_utidx    = r_cnt[SZ_VLEN-1:0];

  // State, counter and op-latch registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_fn     <= '0;
      r_vlen   <= '0;
      r_out_en <= 1'b0;
`ifdef VU_ALU_SEQ_SCALAR_EN
      r_scalar_en <= 1'b0;
      r_scalar    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out_en <= 1'b1;
      if (w_accept) begin
        r_fn   <= issue_fn;
        r_vlen <= issue_vlen;
`ifdef VU_ALU_SEQ_SCALAR_EN
        r_scalar_en <= issue_scalar_en;
        r_scalar    <= issue_scalar;
`endif
      end
    end
  end

  // Next-state, counter update, read request and done pulse.
  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    rd_val      = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (issue_vlen == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          rd_val    = 1'b1;
          w_cnt_nxt = r_cnt + (SZ_VLEN + 1)'(1);
          if (r_cnt == w_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_in_flight) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Element pipeline: stage 2 (ALU issue) and the ALU_LAT-deep stage 3 delay line.
  // NOTE: the index delay line is reset too, so writeback index is clean straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_val <= 1'b0;
      r_s2_idx <= '0;
      r_s3_val <= '0;
      for (int i = 0; i < ALU_LAT; i++) r_s3_idx[i] <= '0;
    end else begin
      r_s2_val    <= rd_val;
      r_s2_idx    <= r_cnt[SZ_VLEN-1:0];
      r_s3_val[0] <= r_s2_val;
      r_s3_idx[0] <= r_s2_idx;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_s3_val[i] <= r_s3_val[i-1];
        r_s3_idx[i] <= r_s3_idx[i-1];
      end
    end
  end

  assign w_s3_val  = r_s3_val[ALU_LAT-1];

  // ALU operands are forced to zero whenever no element is at stage 2.
  assign alu_val   = r_s2_val;
  assign alu_wen   = r_s2_val;
  assign alu_fn    = r_s2_val ? r_fn     : '0;
  assign alu_utidx = r_s2_val ? r_s2_idx : '0;
  assign alu_in0   = r_s2_val ? rd_data0 : '0;
`ifdef VU_ALU_SEQ_SCALAR_EN
  assign alu_in1   = !r_s2_val  ? '0       :
                     r_scalar_en ? r_scalar : rd_data1;
`else
  assign alu_in1   = r_s2_val ? rd_data1 : '0;
`endif

  // Masked elements still retire through stage 3, they just never write.
  assign wb_val    = w_s3_val && alu_wen_masked;
  assign wb_utidx  = w_s3_val ? r_s3_idx[ALU_LAT-1] : '0;
  assign wb_data   = w_s3_val ? alu_out : '0;

endmodule

// File: tb/tb_vu_vxu_alu_seq.sv
// Scoreboard bench for vu_vxu_alu_seq: directed ops push expected read, ALU,
// writeback and done events; a negedge monitor pops and compares them.
// Define VU_ALU_SEQ_SCALAR_EN for both files to exercise the scalar operand.
module tb_vu_vxu_alu_seq;

  localparam logic [7:0] FN_ADD  = 8'h10;  // bit4 = DW64, low nibble = op
  localparam logic [7:0] FN_SUB  = 8'h11;
  localparam logic [7:0] FN_MOVZ = 8'h12;
  localparam logic [7:0] FN_MOVN = 8'h13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_val;
  logic        issue_rdy;
  logic [7:0]  issue_fn;
  logic [7:0]  issue_vlen;
`ifdef VU_ALU_SEQ_SCALAR_EN
  logic        issue_scalar_en;
  logic [63:0] issue_scalar;
`endif
  logic        stall;
  logic        rd_val;
  logic [7:0]  rd_utidx;
  logic [63:0] rd_data0, rd_data1;
  logic        alu_val, alu_wen;
  logic [7:0]  alu_fn, alu_utidx;
  logic [63:0] alu_in0, alu_in1;
  logic        alu_wen_masked;
  logic [63:0] alu_out;
  logic        wb_val;
  logic [7:0]  wb_utidx;
  logic [63:0] wb_data;
  logic        done;

  vu_vxu_alu_seq dut (
    .clk(clk), .reset_n(reset_n),
    .issue_val(issue_val), .issue_rdy(issue_rdy),
    .issue_fn(issue_fn), .issue_vlen(issue_vlen),
`ifdef VU_ALU_SEQ_SCALAR_EN
    .issue_scalar_en(issue_scalar_en), .issue_scalar(issue_scalar),
`endif
    .stall(stall),
    .rd_val(rd_val), .rd_utidx(rd_utidx),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .alu_val(alu_val), .alu_wen(alu_wen), .alu_fn(alu_fn),
    .alu_utidx(alu_utidx), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_wen_masked(alu_wen_masked), .alu_out(alu_out),
    .wb_val(wb_val), .wb_utidx(wb_utidx), .wb_data(wb_data),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int op_start = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand banks: data appears one cycle after the read request.
  logic [63:0] d0 [256];
  logic [63:0] d1 [256];
  always @(posedge clk) begin
    if (rd_val) begin
      rd_data0 <= d0[rd_utidx];
      rd_data1 <= d1[rd_utidx];
    end else begin
      rd_data0 <= 64'hDEAD_BEEF_0000_0000;
      rd_data1 <= 64'h0000_0000_DEAD_BEEF;
    end
  end

  // One-cycle ALU: ADD, SUB, MOVZ (write if in0==0), MOVN (write if in0!=0).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_out        <= '0;
      alu_wen_masked <= 1'b0;
    end else begin
      alu_wen_masked <= 1'b0;
      if (alu_val) begin
        case (alu_fn[3:0])
          4'h0: begin alu_out <= alu_in0 + alu_in1; alu_wen_masked <= alu_wen; end
          4'h1: begin alu_out <= alu_in0 - alu_in1; alu_wen_masked <= alu_wen; end
          4'h2: begin alu_out <= alu_in1; alu_wen_masked <= alu_wen && (alu_in0 == 64'd0); end
          4'h3: begin alu_out <= alu_in1; alu_wen_masked <= alu_wen && (alu_in0 != 64'd0); end
          default: begin alu_out <= 64'd0; alu_wen_masked <= 1'b0; end
        endcase
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] d;
  } ev_t;

  ev_t q_rd[$], q_alu[$], q_wb[$], q_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d of op)", name, act, exp, cyc - op_start);
    end
  endtask

  task automatic push_rd(input int c, input int idx);
    q_rd.push_back('{c, 64'(idx), 64'd0, 64'd0, 64'd0});
  endtask

  task automatic push_alu(input int c, input int idx, input logic [7:0] fn,
                          input logic [63:0] in0, input logic [63:0] in1);
    q_alu.push_back('{c, 64'(idx), 64'(fn), in0, in1});
  endtask

  task automatic push_wb(input int c, input int idx, input logic [63:0] data);
    q_wb.push_back('{c, 64'(idx), data, 64'd0, 64'd0});
  endtask

  task automatic push_done(input int c);
    q_done.push_back('{c, 64'd0, 64'd0, 64'd0, 64'd0});
  endtask

  // Monitor: compares every presented event against the head of its queue.
  always @(negedge clk) begin
    int  rel;
    ev_t ev;
    rel = cyc - op_start;
    if (rd_val) begin
      if (q_rd.size() == 0) check("rd_unexpected", 64'(rd_val), 64'd0);
      else begin
        ev = q_rd.pop_front();
        check("rd_cycle", 64'(rel), 64'(ev.cyc));
        check("rd_utidx", 64'(rd_utidx), ev.a);
      end
    end
    if (alu_val) begin
      if (q_alu.size() == 0) check("alu_unexpected", 64'(alu_val), 64'd0);
      else begin
        ev = q_alu.pop_front();
        check("alu_cycle", 64'(rel), 64'(ev.cyc));
        check("alu_utidx", 64'(alu_utidx), ev.a);
        check("alu_fn", 64'(alu_fn), ev.b);
        check("alu_in0", alu_in0, ev.c);
        check("alu_in1", alu_in1, ev.d);
        check("alu_wen", 64'(alu_wen), 64'd1);
      end
    end else begin
      check("alu_idle_zero", 64'(|{alu_in0, alu_in1, alu_fn, alu_utidx, alu_wen}), 64'd0);
    end
    if (wb_val) begin
      if (q_wb.size() == 0) check("wb_unexpected", 64'(wb_val), 64'd0);
      else begin
        ev = q_wb.pop_front();
        check("wb_cycle", 64'(rel), 64'(ev.cyc));
        check("wb_utidx", 64'(wb_utidx), ev.a);
        check("wb_data", wb_data, ev.b);
      end
    end
    if (done) begin
      if (q_done.size() == 0) check("done_unexpected", 64'(done), 64'd0);
      else begin
        ev = q_done.pop_front();
        check("done_cycle", 64'(rel), 64'(ev.cyc));
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; that cycle becomes op cycle 0.
  task automatic issue(input logic [7:0] fn, input logic [7:0] vlen);
    op_start   = cyc;
    issue_fn   = fn;
    issue_vlen = vlen;
    issue_val  = 1'b1;
    check("issue_rdy_idle", 64'(issue_rdy), 64'd1);
    @(posedge clk); #1;
    issue_val  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic end_op(input string tag);
    check({tag, "_rd_left"},   64'(q_rd.size()),   64'd0);
    check({tag, "_alu_left"},  64'(q_alu.size()),  64'd0);
    check({tag, "_wb_left"},   64'(q_wb.size()),   64'd0);
    check({tag, "_done_left"}, 64'(q_done.size()), 64'd0);
    q_rd.delete(); q_alu.delete(); q_wb.delete(); q_done.delete();
  endtask

  task automatic load_add_banks();
    for (int i = 0; i < 256; i++) begin
      d0[i] = 64'(i);
      d1[i] = 64'd10;
    end
  endtask

  initial begin
    logic [63:0] exp_add [4];
    exp_add[0] = 64'd10; exp_add[1] = 64'd11; exp_add[2] = 64'd12; exp_add[3] = 64'd13;

    reset_n    = 1'b0;
    issue_val  = 1'b0;
    issue_fn   = '0;
    issue_vlen = '0;
    stall      = 1'b0;
`ifdef VU_ALU_SEQ_SCALAR_EN
    issue_scalar_en = 1'b0;
    issue_scalar    = '0;
`endif
    load_add_banks();

    // Reset state.
    #2;
    check("rst_issue_rdy", 64'(issue_rdy), 64'd0);
    check("rst_valids", 64'({rd_val, alu_val, alu_wen, wb_val, done}), 64'd0);
    check("rst_data", 64'(|{wb_data, wb_utidx, alu_in0, alu_in1, rd_utidx}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    #3;
    check("rdy_before_edge", 64'(issue_rdy), 64'd0);
    @(posedge clk); #1;
    check("rdy_after_edge", 64'(issue_rdy), 64'd1);

    // ADD DW64, vlen=4, with an ignored second issue_val during RUN.
    for (int i = 0; i < 4; i++) begin
      push_rd(1 + i, i);
      push_alu(2 + i, i, FN_ADD, 64'(i), 64'd10);
      push_wb(3 + i, i, exp_add[i]);
    end
    push_done(7);
    issue(FN_ADD, 8'd4);
    @(posedge clk); #1;                    // op cycle 2
    issue_val  = 1'b1;
    issue_vlen = 8'd9;
    check("rdy_busy", 64'(issue_rdy), 64'd0);
    @(posedge clk); #1;
    issue_val  = 1'b0;
    wait_done();
    end_op("add4");

    // vlen=0: straight to DRAIN, done on the next cycle, nothing else.
    push_done(1);
    issue(FN_ADD, 8'd0);
    wait_done();
    check("rdy_after_vlen0", 64'(issue_rdy), 64'd1);
    end_op("vlen0");

    // MOVZ: in0 bit0 = 1,0,1,0 so only elements 1 and 3 write.
    d0[0] = 64'd1; d0[1] = 64'd0; d0[2] = 64'd1; d0[3] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      d1[i] = 64'(100 + i);
      push_rd(1 + i, i);
      push_alu(2 + i, i, FN_MOVZ, d0[i], d1[i]);
    end
    push_wb(4, 1, 64'd101);
    push_wb(6, 3, 64'd103);
    push_done(7);
    issue(FN_MOVZ, 8'd4);
    wait_done();
    end_op("movz");

    // Stall in op cycles 2-4, vlen=3.
    load_add_banks();
    push_rd(1, 0); push_rd(5, 1); push_rd(6, 2);
    push_alu(2, 0, FN_ADD, 64'd0, 64'd10);
    push_alu(6, 1, FN_ADD, 64'd1, 64'd10);
    push_alu(7, 2, FN_ADD, 64'd2, 64'd10);
    push_wb(3, 0, 64'd10); push_wb(7, 1, 64'd11); push_wb(8, 2, 64'd12);
    push_done(9);
    issue(FN_ADD, 8'd3);
    @(posedge clk); #1;                    // op cycle 2
    stall = 1'b1;
    @(posedge clk); @(posedge clk);
    @(posedge clk); #1;                    // op cycle 5
    stall = 1'b0;
    wait_done();
    end_op("stall");

    // Reset in op cycle 3 of a vlen=8 op: nothing further, no done.
    push_rd(1, 0); push_rd(2, 1);
    push_alu(2, 0, FN_ADD, 64'd0, 64'd10);
    issue(FN_ADD, 8'd8);
    @(posedge clk); #1;                    // op cycle 2
    @(posedge clk); #1;                    // op cycle 3
    reset_n = 1'b0;
    #1;
    check("midrst_valids", 64'({rd_val, alu_val, wb_val, done, issue_rdy}), 64'd0);
    check("midrst_wb_data", wb_data, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst_rdy_low", 64'(issue_rdy), 64'd0);
    @(posedge clk); #1;
    check("midrst_rdy_high", 64'(issue_rdy), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    end_op("midrst");

    // New op after the mid-op reset.
    push_rd(1, 0); push_rd(2, 1);
    push_alu(2, 0, FN_ADD, 64'd0, 64'd10);
    push_alu(3, 1, FN_ADD, 64'd1, 64'd10);
    push_wb(3, 0, 64'd10); push_wb(4, 1, 64'd11);
    push_done(5);
    issue(FN_ADD, 8'd2);
    wait_done();
    end_op("postrst");

`ifdef VU_ALU_SEQ_SCALAR_EN
    // SUB with scalar 5 and in0=20: every element writes 15, rd_data1 ignored.
    for (int i = 0; i < 3; i++) begin
      d0[i] = 64'd20;
      d1[i] = 64'(7 * i + 3);
      push_rd(1 + i, i);
      push_alu(2 + i, i, FN_SUB, 64'd20, 64'd5);
      push_wb(3 + i, i, 64'd15);
    end
    push_done(6);
    issue_scalar_en = 1'b1;
    issue_scalar    = 64'd5;
    issue(FN_SUB, 8'd3);
    issue_scalar_en = 1'b0;
    issue_scalar    = 64'd99;
    wait_done();
    end_op("scalar");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // MOVN encoding is kept for the ALU model; referenced here so it is not dead.
  logic [7:0] unused_fn_movn;
  assign unused_fn_movn = FN_MOVN;

endmodule
